// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: assembles big-endian words, writes them to the
// core's word memory, verifies an XOR checksum and then releases the core.
module mips32_prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  localparam logic [16:0] DEPTH    = 17'(2 ** ADDR_W);
  localparam logic [1:0]  ERR_NONE = 2'b00;
  localparam logic [1:0]  ERR_RNG  = 2'b01;
  localparam logic [1:0]  ERR_CNT  = 2'b10;
  localparam logic [1:0]  ERR_SUM  = 2'b11;

  typedef enum logic [3:0] {
    S_SYNC, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic              accept_c;
  logic [15:0]       n_c;
  logic [16:0]       end_c;

  assign accept_c = in_valid && in_ready_q;
  assign n_c      = {cnt_q[15:8], in_data};
  assign end_c    = {1'b0, addr_q} + {1'b0, n_c};

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    run_d       = run_q;
    err_d       = err_q;

    if (accept_c) begin
      unique case (state_q)
        S_SYNC: begin
          if (in_data == SYNC_BYTE) state_d = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          addr_d[15:8] = in_data;
          state_d      = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d[7:0] = in_data;
          state_d     = S_CNT_HI;
        end
        S_CNT_HI: begin
          cnt_d[15:8] = in_data;
          state_d     = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_d      = n_c;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          csum_d     = 8'd0;
          // Upper address bits beyond ADDR_W also trip this 17-bit check
          if (n_c == 16'd0) begin
            state_d = S_ERROR;
            err_d   = ERR_CNT;
          end else if (end_c > DEPTH) begin
            state_d = S_ERROR;
            err_d   = ERR_RNG;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d     = {word_q[23:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[ADDR_W-1:0] + word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = {word_q[23:0], in_data};
            word_cnt_d  = word_cnt_q + 16'd1;
            if (word_cnt_q == cnt_q - 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            run_d   = 1'b1;
            err_d   = ERR_NONE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_SUM;
          end
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
    done_d     = (state_d == S_DONE) || (state_d == S_ERROR);
    busy_d     = in_ready_d && (state_d != S_SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      addr_q      <= 16'd0;
      cnt_q       <= 16'd0;
      word_q      <= 32'd0;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= 16'd0;
      csum_q      <= 8'd0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: framed loads, error frames, gaps, reset.
module tb_mips32_prog_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              run;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;

  int tests = 0;
  int fails = 0;

  int          nw = 0;
  logic [31:0] wa [0:15];
  logic [31:0] wd [0:15];

  mips32_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .run(run), .busy(busy), .done(done),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (nw < 16) begin
        wa[nw] = 32'(mem_addr);
        wd[nw] = mem_wdata;
      end
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nw = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_frame(input logic [7:0] bytes [], input int gap);
    foreach (bytes[i]) send(bytes[i], gap);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_good(input string tag);
    check({tag, "_nw"}, 32'(nw), 32'd2);
    check({tag, "_a0"}, wa[0], 32'd5);
    check({tag, "_d0"}, wd[0], 32'h01020304);
    check({tag, "_a1"}, wa[1], 32'd6);
    check({tag, "_d1"}, wd[1], 32'h10203040);
    check({tag, "_run"}, 32'(run), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err_code), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] good [] = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h02,
                          8'h01, 8'h02, 8'h03, 8'h04,
                          8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
  logic [7:0] junk [] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h01,
                          8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
  logic [7:0] badck [] = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h02,
                           8'h01, 8'h02, 8'h03, 8'h04,
                           8'h10, 8'h20, 8'h30, 8'h40, 8'h45};
  logic [7:0] rng [] = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02};
  logic [7:0] zc  [] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] hi  [] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h01};

  initial begin
    do_reset();
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);

    // Good frame, back-to-back bytes
    send(8'hA5, 0);
    check("sync_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 14; i++) send(good[i], 0);
    repeat (2) @(posedge clk);
    #1;
    check_good("good");

    // Sticky DONE ignores further bytes
    send(8'hA5, 2);
    check("sticky_done", 32'(done), 32'd1);
    check("sticky_run", 32'(run), 32'd1);

    do_reset();
    send_frame(junk, 0);
    check("junk_nw", 32'(nw), 32'd1);
    check("junk_a0", wa[0], 32'd0);
    check("junk_d0", wd[0], 32'hDEADBEEF);
    check("junk_run", 32'(run), 32'd1);
    check("junk_err", 32'(err_code), 32'd0);

    do_reset();
    send_frame(badck, 0);
    check("bad_nw", 32'(nw), 32'd2);
    check("bad_d1", wd[1], 32'h10203040);
    check("bad_run", 32'(run), 32'd0);
    check("bad_done", 32'(done), 32'd1);
    check("bad_err", 32'(err_code), 32'd3);
    check("bad_rdy", 32'(in_ready), 32'd0);

    do_reset();
    send_frame(rng, 0);
    check("rng_err", 32'(err_code), 32'd1);
    check("rng_done", 32'(done), 32'd1);
    check("rng_nw", 32'(nw), 32'd0);

    do_reset();
    send_frame(zc, 0);
    check("zc_err", 32'(err_code), 32'd2);
    check("zc_done", 32'(done), 32'd1);

    // Start address 0x0400 exceeds the 10-bit range even with N = 1
    do_reset();
    send_frame(hi, 0);
    check("hi_err", 32'(err_code), 32'd1);
    check("hi_nw", 32'(nw), 32'd0);

    // Good frame with two idle cycles between bytes
    do_reset();
    send_frame(good, 2);
    check_good("gap");

    // Reset right after the 7th payload byte
    do_reset();
    for (int i = 0; i < 12; i++) send(good[i], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_we", 32'(mem_we), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rdy", 32'(in_ready), 32'd1);
    check("mid_run", 32'(run), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_nw", 32'(nw), 32'd1);
    check("mid_done", 32'(done), 32'd0);
    nw = 0;
    send_frame(good, 0);
    check_good("fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
